// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store engine placed after the controller's memory-access stage.
//   A rising edge on (MemRead | MemWrite) in IDLE starts one req/ack
//   transaction on the data-memory port. For stores it builds the byte strobes
//   and lane-replicated data (SB/SH/SW). For loads it selects a byte or halfword
//   lane and sign- or zero-extends it (LB/LBU/LH/LHU/LW).
//
//   Parameter TIMEOUT_CYC : number of REQ cycles without mem_ack before the
//                           request is abandoned with err=1 (0 = wait forever).
//   Macro MEM_ALIGN_CHECK_EN : when defined, a misaligned halfword or word
//                           access is refused without touching memory and
//                           completes with err=1.
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  extmode1,
    input  logic [2:0]  extmode2,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Load modes (extmode1)
    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_BU = 3'b010;
    localparam logic [2:0] LD_H  = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    // Store modes (extmode2); any other code behaves as a word store
    localparam logic [2:0] ST_W = 3'b000;
    localparam logic [2:0] ST_B = 3'b010;
    localparam logic [2:0] ST_H = 3'b100;

    // The counter only needs to reach TIMEOUT_CYC-1: that value marks the last REQ cycle.
    localparam int unsigned    CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q,  state_d;
    logic               strb_q;               // strobe level seen last cycle
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               err_q,    err_d;
    logic               we_q,     we_d;
    logic [31:0]        addr_q,   addr_d;
    logic [3:0]         wstrb_q,  wstrb_d;
    logic [31:0]        wdata_q,  wdata_d;
    logic [2:0]         lmode_q,  lmode_d;
    logic [1:0]         loff_q,   loff_d;
    logic [31:0]        rdata_q,  rdata_d;

    logic               strobe;
    logic               trigger;
    logic               misalign;
    logic               last_cycle;

    // Byte enables for a store of the given mode at the given byte offset.
    function automatic logic [3:0] store_strb(input logic [2:0] mode, input logic [1:0] off);
        logic [3:0] s;
        case (mode)
            ST_B:    s = 4'b0001 << off;
            ST_H:    s = 4'b0011 << {off[1], 1'b0};
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    // Store data replicated into every lane so the strobes alone pick the target bytes.
    function automatic logic [31:0] store_data(input logic [2:0] mode, input logic [31:0] d);
        logic [31:0] r;
        case (mode)
            ST_B:    r = {4{d[7:0]}};
            ST_H:    r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    // Lane select and extension of a returned memory word.
    function automatic logic [31:0] load_ext(input logic [2:0] mode, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (mode)
            LD_B:    r = {{24{b[7]}}, b};
            LD_BU:   r = {24'd0, b};
            LD_H:    r = {{16{h[15]}}, h};
            LD_HU:   r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    assign strobe     = MemRead | MemWrite;
    assign trigger    = (state_q == S_IDLE) && strobe && !strb_q;
    assign last_cycle = (TIMEOUT_CYC > 0) && (cnt_q == CNT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
    // Flag a halfword access on an odd address or a word access off a word boundary.
    always_comb begin
        logic is_half;
        logic is_byte;
        if (MemWrite) begin
            is_half = (extmode2 == ST_H);
            is_byte = (extmode2 == ST_B);
        end else begin
            is_half = (extmode1 == LD_H) || (extmode1 == LD_HU);
            is_byte = (extmode1 == LD_B) || (extmode1 == LD_BU);
        end
        if (is_half)
            misalign = addr[0];
        else
            misalign = !is_byte && (addr[1:0] != 2'b00);
    end
`else
    // Without the check, halfwords use addr[1] only and words ignore addr[1:0].
    assign misalign = 1'b0;
`endif

    // Next-state logic: trigger decode, request capture, ack/timeout handling.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        lmode_d = lmode_q;
        loff_d  = loff_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    if ((MemRead && MemWrite) || misalign) begin
                        // Refused: no request, report the error on the next cycle.
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        we_d    = MemWrite;
                        addr_d  = {addr[31:2], 2'b00};
                        wstrb_d = MemWrite ? store_strb(extmode2, addr[1:0]) : 4'b0000;
                        wdata_d = MemWrite ? store_data(extmode2, wdata) : 32'd0;
                        lmode_d = extmode1;
                        loff_d  = addr[1:0];
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    // An ack in the last counted cycle still completes normally.
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    if (!we_q)
                        rdata_d = load_ext(lmode_q, loff_q, mem_rdata);
                end else if (last_cycle) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; the strobe history resets high so a
    // strobe already asserted when reset releases does not start an access.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            strb_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wstrb_q <= 4'b0000;
            wdata_q <= 32'd0;
            lmode_q <= LD_W;
            loff_q  <= 2'd0;
            rdata_q <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            strb_q  <= strobe;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            lmode_q <= lmode_d;
            loff_q  <= loff_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs come straight from registers, so an asynchronous reset clears mem_req at once.
    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wstrb = wstrb_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed bench for mem_access_unit (TIMEOUT_CYC = 16). Inputs are driven
//   1 time unit after each rising edge and outputs are sampled at that point.
//   The misaligned-word case follows MEM_ALIGN_CHECK_EN if it is defined.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        rstn;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  extmode1;
    logic [2:0]  extmode2;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_rd;
    int          n;

    mem_access_unit #(.TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .extmode1  (extmode1),
        .extmode2  (extmode2),
        .addr      (addr),
        .wdata     (wdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete access acknowledged in the first REQ cycle.
    task automatic txn(input string tag, input logic rd, input logic wr,
                       input logic [2:0] m1, input logic [2:0] m2,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                       input logic [3:0] e_strb, input logic [31:0] e_wdata,
                       input logic [31:0] e_rdata);
        MemRead  = rd;
        MemWrite = wr;
        extmode1 = m1;
        extmode2 = m2;
        addr     = a;
        wdata    = wd;
        step();
        // Scramble inputs: request fields must stay as captured at the trigger.
        addr     = ~a;
        wdata    = ~wd;
        extmode1 = 3'b111;
        extmode2 = 3'b111;
        check({tag, ".req"},   32'(mem_req), 32'd1);
        check({tag, ".we"},    32'(mem_we), 32'(wr));
        check({tag, ".addr"},  mem_addr, {a[31:2], 2'b00});
        check({tag, ".wstrb"}, 32'(mem_wstrb), 32'(e_strb));
        if (wr)
            check({tag, ".wdata"}, mem_wdata, e_wdata);
        mem_ack   = 1'b1;
        mem_rdata = word;
        step();
        check({tag, ".done"},  32'(done), 32'd1);
        check({tag, ".err"},   32'(err), 32'd0);
        check({tag, ".req_off"}, 32'(mem_req), 32'd0);
        check({tag, ".rdata"}, rdata, e_rdata);
        mem_ack  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        step();
        check({tag, ".done_off"}, 32'(done), 32'd0);
        check({tag, ".idle"},     32'(busy), 32'd0);
    endtask

    initial begin
        rstn      = 1'b0;
        MemRead   = 1'b1;          // held across reset release
        MemWrite  = 1'b0;
        extmode1  = 3'b000;
        extmode2  = 3'b000;
        addr      = 32'd0;
        wdata     = 32'd0;
        mem_rdata = 32'd0;
        mem_ack   = 1'b0;
        exp_rd    = 32'd0;

        // ---- reset state ----
        step();
        step();
        check("rst.req",   32'(mem_req), 32'd0);
        check("rst.busy",  32'(busy), 32'd0);
        check("rst.done",  32'(done), 32'd0);
        check("rst.err",   32'(err), 32'd0);
        check("rst.rdata", rdata, 32'd0);
        check("rst.wstrb", 32'(mem_wstrb), 32'd0);

        // Strobe held high through reset release must not start an access.
        rstn = 1'b1;
        step();
        step();
        step();
        check("rst_hold.busy", 32'(busy), 32'd0);
        check("rst_hold.req",  32'(mem_req), 32'd0);
        MemRead = 1'b0;
        step();

        // ---- stores ----
        txn("sw",  1'b0, 1'b1, 3'b000, 3'b000, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,
            4'b1111, 32'hDEAD_BEEF, exp_rd);
        txn("sb3", 1'b0, 1'b1, 3'b000, 3'b010, 32'h0000_0103, 32'h0000_00A5, 32'h0,
            4'b1000, 32'hA5A5_A5A5, exp_rd);
        txn("sb1", 1'b0, 1'b1, 3'b000, 3'b010, 32'h0000_0101, 32'hFFFF_FF37, 32'h0,
            4'b0010, 32'h3737_3737, exp_rd);
        txn("sh2", 1'b0, 1'b1, 3'b000, 3'b100, 32'h0000_0102, 32'h0000_1234, 32'h0,
            4'b1100, 32'h1234_1234, exp_rd);
        txn("sh0", 1'b0, 1'b1, 3'b000, 3'b100, 32'h0000_0200, 32'hAAAA_5678, 32'h0,
            4'b0011, 32'h5678_5678, exp_rd);
        txn("sx",  1'b0, 1'b1, 3'b000, 3'b110, 32'h0000_0301, 32'hCAFE_F00D, 32'h0,
            4'b1111, 32'hCAFE_F00D, exp_rd);

        // ---- loads from word 0x80F17F01 ----
        txn("lb1",  1'b1, 1'b0, 3'b001, 3'b000, 32'h0000_0001, 32'h0, 32'h80F1_7F01,
            4'b0000, 32'h0, 32'h0000_007F);
        txn("lb3",  1'b1, 1'b0, 3'b001, 3'b000, 32'h0000_0003, 32'h0, 32'h80F1_7F01,
            4'b0000, 32'h0, 32'hFFFF_FF80);
        txn("lbu3", 1'b1, 1'b0, 3'b010, 3'b000, 32'h0000_0003, 32'h0, 32'h80F1_7F01,
            4'b0000, 32'h0, 32'h0000_0080);
        txn("lb2",  1'b1, 1'b0, 3'b001, 3'b000, 32'h0000_0002, 32'h0, 32'h80F1_7F01,
            4'b0000, 32'h0, 32'hFFFF_FFF1);
        txn("lh2",  1'b1, 1'b0, 3'b011, 3'b000, 32'h0000_0002, 32'h0, 32'h80F1_7F01,
            4'b0000, 32'h0, 32'hFFFF_80F1);
        txn("lhu2", 1'b1, 1'b0, 3'b100, 3'b000, 32'h0000_0002, 32'h0, 32'h80F1_7F01,
            4'b0000, 32'h0, 32'h0000_80F1);
        txn("lh0",  1'b1, 1'b0, 3'b011, 3'b000, 32'h0000_0000, 32'h0, 32'h80F1_7F01,
            4'b0000, 32'h0, 32'h0000_7F01);
        txn("lw0",  1'b1, 1'b0, 3'b000, 3'b000, 32'h0000_0000, 32'h0, 32'h80F1_7F01,
            4'b0000, 32'h0, 32'h80F1_7F01);
        txn("lx",   1'b1, 1'b0, 3'b111, 3'b000, 32'h0000_0004, 32'h0, 32'h1357_9BDF,
            4'b0000, 32'h0, 32'h1357_9BDF);
        exp_rd = 32'h1357_9BDF;

        // Store leaves the last load result untouched.
        txn("sw_keep", 1'b0, 1'b1, 3'b000, 3'b000, 32'h0000_0010, 32'h0BAD_F00D, 32'hFFFF_FFFF,
            4'b1111, 32'h0BAD_F00D, exp_rd);

        // ---- misaligned word load ----
`ifdef MEM_ALIGN_CHECK_EN
        MemRead  = 1'b1;
        extmode1 = 3'b000;
        addr     = 32'h0000_0102;
        step();
        check("mis.req",  32'(mem_req), 32'd0);
        check("mis.done", 32'(done), 32'd1);
        check("mis.err",  32'(err), 32'd1);
        check("mis.rdata", rdata, exp_rd);
        MemRead = 1'b0;
        step();
        check("mis.idle", 32'(busy), 32'd0);
`else
        txn("lw_mis", 1'b1, 1'b0, 3'b000, 3'b000, 32'h0000_0102, 32'h0, 32'h2468_ACE0,
            4'b0000, 32'h0, 32'h2468_ACE0);
        exp_rd = 32'h2468_ACE0;
`endif

        // ---- timeout: no ack at all ----
        MemRead   = 1'b1;
        extmode1  = 3'b000;
        addr      = 32'h0000_0200;
        mem_rdata = 32'h5555_5555;
        step();
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            step();
        end
        check("tmo.req_cycles", 32'(n), 32'd16);
        check("tmo.done",  32'(done), 32'd1);
        check("tmo.err",   32'(err), 32'd1);
        check("tmo.rdata", rdata, exp_rd);
        MemRead = 1'b0;
        step();
        check("tmo.idle", 32'(busy), 32'd0);

        // ---- ack in the 16th REQ cycle beats the timeout ----
        MemRead = 1'b1;
        step();                          // REQ cycle 1
        for (int i = 0; i < 15; i++)
            step();                      // now in REQ cycle 16
        check("ack16.req", 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1122_3344;
        step();
        check("ack16.done",  32'(done), 32'd1);
        check("ack16.err",   32'(err), 32'd0);
        check("ack16.rdata", rdata, 32'h1122_3344);
        exp_rd   = 32'h1122_3344;
        mem_ack  = 1'b0;
        MemRead  = 1'b0;
        step();

        // ---- strobe held 4 cycles: exactly one access ----
        MemWrite = 1'b1;
        extmode2 = 3'b000;
        addr     = 32'h0000_0040;
        wdata    = 32'h0000_0001;
        mem_ack  = 1'b1;                 // ack whenever requested
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (mem_req) n++;
        end
        check("hold.req_count", 32'(n), 32'd1);
        check("hold.idle", 32'(busy), 32'd0);
        MemWrite = 1'b0;
        mem_ack  = 1'b0;
        step();

        // ---- ack outside REQ is ignored ----
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        step();
        check("stray.done",  32'(done), 32'd0);
        check("stray.rdata", rdata, exp_rd);
        mem_ack = 1'b0;
        step();

        // ---- both strobes ----
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        step();
        check("both.req",  32'(mem_req), 32'd0);
        check("both.done", 32'(done), 32'd1);
        check("both.err",  32'(err), 32'd1);
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        step();
        check("both.done_off", 32'(done), 32'd0);
        check("both.rdata", rdata, exp_rd);

        // ---- reset in the middle of REQ ----
        MemRead  = 1'b1;
        extmode1 = 3'b000;
        addr     = 32'h0000_0080;
        step();
        check("rstmid.req_on", 32'(mem_req), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("rstmid.req_off", 32'(mem_req), 32'd0);
        check("rstmid.done",    32'(done), 32'd0);
        MemRead = 1'b0;
        step();
        rstn = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done || mem_req) n++;
        end
        check("rstmid.no_done", 32'(n), 32'd0);
        check("rstmid.rdata", rdata, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
